// File: rtl/aes128_key_expand.sv
// rtl/aes128_key_expand.sv - iterative AES-128 key schedule with an 11-entry round-key file
// Optional macro AES_KEY_EXP_PIPE_EN: registers SubWord, so each round takes two cycles.
module aes128_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] IN_KEY,
    input  logic         KEY_VALID,
    output logic         KEY_ACCEPT,
    output logic         BUSY,
    output logic         KEY_READY,
    input  logic [3:0]   RK_SEL,
    output logic [127:0] ROUND_KEY,
    output logic [127:0] LAST_KEY
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] READY  = 2'd2;
    localparam logic [3:0] LAST_IDX = 4'(NR);

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TAB[2047 - 8 * int'(a) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] rk_q [0:NR];
    logic [127:0] round_key_q;
    logic [127:0] prev_key;
    logic [127:0] rk_next_d;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  sub_use;
    logic [31:0]  temp;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [3:0]   prev_idx;
    logic         rk_wr;
`ifdef AES_KEY_EXP_PIPE_EN
    logic         phase_q, phase_d;
    logic [31:0]  sub_q;
`endif

    assign KEY_ACCEPT = KEY_VALID && (state_q == IDLE || state_q == READY);
    assign BUSY       = (state_q == EXPAND);
    assign KEY_READY  = (state_q == READY);
    assign ROUND_KEY  = round_key_q;
    assign LAST_KEY   = rk_q[NR];

    // rnd_q is 1..10 while expanding; the guard keeps the idle read in range.
    assign prev_idx = rnd_q - 4'd1;
    assign prev_key = (rnd_q != 4'd0) ? rk_q[prev_idx] : '0;
    assign rot_word = {prev_key[23:0], prev_key[31:24]};
    assign sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                       sbox(rot_word[15:8]),  sbox(rot_word[7:0])};

`ifdef AES_KEY_EXP_PIPE_EN
    assign sub_use = sub_q;
`else
    assign sub_use = sub_word;
`endif

    assign temp      = sub_use ^ {rcon(rnd_q), 24'h0};
    assign w0_n      = prev_key[127:96] ^ temp;
    assign w1_n      = prev_key[95:64]  ^ w0_n;
    assign w2_n      = prev_key[63:32]  ^ w1_n;
    assign w3_n      = prev_key[31:0]   ^ w2_n;
    assign rk_next_d = {w0_n, w1_n, w2_n, w3_n};

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        rk_wr   = 1'b0;
`ifdef AES_KEY_EXP_PIPE_EN
        phase_d = phase_q;
`endif
        if (KEY_ACCEPT) begin
            state_d = EXPAND;
            rnd_d   = 4'd1;
`ifdef AES_KEY_EXP_PIPE_EN
            phase_d = 1'b0;
`endif
        end else if (state_q == EXPAND) begin
`ifdef AES_KEY_EXP_PIPE_EN
            phase_d = ~phase_q;
            rk_wr   = phase_q;
`else
            rk_wr   = 1'b1;
`endif
            if (rk_wr) begin
                if (rnd_q == LAST_IDX) begin
                    state_d = READY;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            round_key_q <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
`ifdef AES_KEY_EXP_PIPE_EN
            phase_q <= 1'b0;
            sub_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            round_key_q <= (RK_SEL <= LAST_IDX) ? rk_q[RK_SEL] : '0;
            if (KEY_ACCEPT) begin
                rk_q[0] <= IN_KEY;
            end else if (rk_wr) begin
                rk_q[rnd_q] <= rk_next_d;
            end
`ifdef AES_KEY_EXP_PIPE_EN
            phase_q <= phase_d;
            if (state_q == EXPAND && !phase_q) begin
                sub_q <= sub_word;
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes128_key_expand.sv
// tb/tb_aes128_key_expand.sv - self-checking bench for aes128_key_expand
// Reference schedule is built from GF(2^8) arithmetic and the word-level key expansion.
module tb_aes128_key_expand;

`ifdef AES_KEY_EXP_PIPE_EN
    localparam int LAT = 20;
`else
    localparam int LAT = 10;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] IN_KEY = '0;
    logic         KEY_VALID = 1'b0;
    logic         KEY_ACCEPT, BUSY, KEY_READY;
    logic [3:0]   RK_SEL = 4'd0;
    logic [127:0] ROUND_KEY, LAST_KEY;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] exp_rk [0:10];

    aes128_key_expand dut (
        .clk(clk), .rst(rst), .IN_KEY(IN_KEY), .KEY_VALID(KEY_VALID),
        .KEY_ACCEPT(KEY_ACCEPT), .BUSY(BUSY), .KEY_READY(KEY_READY),
        .RK_SEL(RK_SEL), .ROUND_KEY(ROUND_KEY), .LAST_KEY(LAST_KEY)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_tab[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic ref_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic do_load(input logic [127:0] k, output int n);
        IN_KEY = k;
        KEY_VALID = 1'b1;
        n = 0;
        #1;
        while (!KEY_ACCEPT && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        @(posedge clk); #1;
        KEY_VALID = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!KEY_READY && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic read_rk(input logic [3:0] sel, output logic [127:0] v);
        RK_SEL = sel;
        @(posedge clk); #1;
        v = ROUND_KEY;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (KEY_READY !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", KEY_READY); end
        checks++; if (LAST_KEY !== 128'h0) begin errors++; $display("FAIL reset_last got=%h exp=0", LAST_KEY); end
        checks++; if (ROUND_KEY !== 128'h0) begin errors++; $display("FAIL reset_rk got=%h exp=0", ROUND_KEY); end
        checks++; if (KEY_ACCEPT !== 1'b0) begin errors++; $display("FAIL reset_accept got=%b exp=0", KEY_ACCEPT); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fips_vector();
        int n;
        logic [127:0] v, rk1;
        ref_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        do_load(128'h2b7e151628aed2a6abf7158809cf4f3c, n);
        checks++; if (BUSY !== 1'b1 || KEY_READY !== 1'b0) begin errors++;
            $display("FAIL fips_after_accept busy=%b ready=%b exp busy=1 ready=0", BUSY, KEY_READY); end
        wait_ready(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL fips_latency got=%0d exp=%0d", n, LAT); end
        rk1 = '0;
        for (int s = 0; s <= 10; s++) begin
            read_rk(4'(s), v);
            if (s == 1) rk1 = v;
            checks++; if (v !== exp_rk[s]) begin errors++; $display("FAIL fips_rk%0d got=%h exp=%h", s, v, exp_rk[s]); end
        end
        checks++; if (rk1 !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++;
            $display("FAIL fips_rk1_const got=%h exp=a0fafe1788542cb123a339392a6c7605", rk1); end
        checks++; if (LAST_KEY !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++;
            $display("FAIL fips_last_const got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", LAST_KEY); end
    endtask

    task automatic test_zero_key_sweep();
        int n;
        logic [127:0] v, rk1, expv;
        ref_expand(128'h0);
        do_load(128'h0, n);
        wait_ready(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", n, LAT); end
        rk1 = '0;
        for (int s = 0; s < 16; s++) begin
            read_rk(4'(s), v);
            if (s == 1) rk1 = v;
            expv = (s <= 10) ? exp_rk[s] : 128'h0;
            checks++; if (v !== expv) begin errors++; $display("FAIL zero_sel%0d got=%h exp=%h", s, v, expv); end
        end
        checks++; if (rk1 !== 128'h62636363626363636263636362636363) begin errors++;
            $display("FAIL zero_rk1_const got=%h exp=62636363626363636263636362636363", rk1); end
        checks++; if (LAST_KEY !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin errors++;
            $display("FAIL zero_rk10_const got=%h exp=b4ef5bcb3e92e21123e951cf6f8f188e", LAST_KEY); end
    endtask

    task automatic test_random_keys();
        int n;
        logic [127:0] k, v;
        for (int t = 0; t < 4; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            ref_expand(k);
            do_load(k, n);
            wait_ready(n);
            checks++; if (n != LAT) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, n, LAT); end
            checks++; if (LAST_KEY !== exp_rk[10]) begin errors++; $display("FAIL rand%0d_last got=%h exp=%h", t, LAST_KEY, exp_rk[10]); end
            for (int s = 0; s <= 10; s++) begin
                read_rk(4'(s), v);
                checks++; if (v !== exp_rk[s]) begin errors++; $display("FAIL rand%0d_rk%0d got=%h exp=%h", t, s, v, exp_rk[s]); end
            end
        end
    endtask

    task automatic test_hold_during_expand();
        int n;
        logic [127:0] ka, kb;
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = ~ka;
        do_load(ka, n);
        IN_KEY = kb;
        KEY_VALID = 1'b1;
        #1;
        n = 0;
        while (!KEY_READY && n < 200) begin
            checks++; if (KEY_ACCEPT !== 1'b0) begin errors++; $display("FAIL hold_accept_c%0d got=%b exp=0", n, KEY_ACCEPT); end
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != LAT) begin errors++; $display("FAIL hold_latency got=%0d exp=%0d", n, LAT); end
        ref_expand(ka);
        checks++; if (LAST_KEY !== exp_rk[10]) begin errors++; $display("FAIL hold_first_last got=%h exp=%h", LAST_KEY, exp_rk[10]); end
        checks++; if (KEY_ACCEPT !== 1'b1) begin errors++; $display("FAIL hold_accept_ready got=%b exp=1", KEY_ACCEPT); end
        @(posedge clk); #1;
        KEY_VALID = 1'b0;
        checks++; if (KEY_READY !== 1'b0 || BUSY !== 1'b1) begin errors++;
            $display("FAIL hold_restart ready=%b busy=%b exp ready=0 busy=1", KEY_READY, BUSY); end
        wait_ready(n);
        ref_expand(kb);
        checks++; if (n != LAT) begin errors++; $display("FAIL hold_second_latency got=%0d exp=%0d", n, LAT); end
        checks++; if (LAST_KEY !== exp_rk[10]) begin errors++; $display("FAIL hold_second_last got=%h exp=%h", LAST_KEY, exp_rk[10]); end
    endtask

    task automatic test_back_to_back();
        int n, total;
        logic [127:0] keys [0:2];
        for (int i = 0; i < 3; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
        do_load(keys[0], n);
        total = 0;
        for (int i = 1; i < 3; i++) begin
            IN_KEY = keys[i];
            KEY_VALID = 1'b1;
            wait_ready(n);
            total += n;
            checks++; if (KEY_ACCEPT !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d got=%b exp=1", i, KEY_ACCEPT); end
            @(posedge clk); #1;
            total++;
        end
        KEY_VALID = 1'b0;
        wait_ready(n);
        total += n;
        ref_expand(keys[2]);
        checks++; if (total != 3 * LAT + 2) begin errors++; $display("FAIL b2b_total_cycles got=%0d exp=%0d", total, 3 * LAT + 2); end
        checks++; if (LAST_KEY !== exp_rk[10]) begin errors++; $display("FAIL b2b_last got=%h exp=%h", LAST_KEY, exp_rk[10]); end
    endtask

    task automatic test_reset_mid_expand();
        int n;
        logic [127:0] k, v;
        RK_SEL = 4'd10;
        k = {$urandom, $urandom, $urandom, $urandom};
        do_load(k, n);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (BUSY !== 1'b0 || KEY_READY !== 1'b0) begin errors++;
            $display("FAIL midrst_flags busy=%b ready=%b exp 0 0", BUSY, KEY_READY); end
        checks++; if (LAST_KEY !== 128'h0) begin errors++; $display("FAIL midrst_last got=%h exp=0", LAST_KEY); end
        checks++; if (ROUND_KEY !== 128'h0) begin errors++; $display("FAIL midrst_rk got=%h exp=0", ROUND_KEY); end
        rst = 1'b0;
        read_rk(4'd10, v);
        checks++; if (v !== 128'h0) begin errors++; $display("FAIL midrst_rk10_cleared got=%h exp=0", v); end
        KEY_VALID = 1'b1;
        #1;
        checks++; if (KEY_ACCEPT !== 1'b1) begin errors++; $display("FAIL midrst_idle_accept got=%b exp=1", KEY_ACCEPT); end
        KEY_VALID = 1'b0;
        k = {$urandom, $urandom, $urandom, $urandom};
        ref_expand(k);
        do_load(k, n);
        wait_ready(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL midrst_reload_latency got=%0d exp=%0d", n, LAT); end
        checks++; if (LAST_KEY !== exp_rk[10]) begin errors++; $display("FAIL midrst_reload_last got=%h exp=%h", LAST_KEY, exp_rk[10]); end
    endtask

    task automatic test_reset_with_valid();
        logic [127:0] v;
        RK_SEL = 4'd0;
        IN_KEY = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        KEY_VALID = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (BUSY !== 1'b0 || KEY_READY !== 1'b0) begin errors++;
            $display("FAIL rstvalid_flags busy=%b ready=%b exp 0 0", BUSY, KEY_READY); end
        checks++; if (LAST_KEY !== 128'h0) begin errors++; $display("FAIL rstvalid_last got=%h exp=0", LAST_KEY); end
        checks++; if (ROUND_KEY !== 128'h0) begin errors++; $display("FAIL rstvalid_rk got=%h exp=0", ROUND_KEY); end
        rst = 1'b0;
        KEY_VALID = 1'b0;
        read_rk(4'd0, v);
        checks++; if (v !== 128'h0) begin errors++; $display("FAIL rstvalid_rk0_not_loaded got=%h exp=0", v); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rstvalid_not_busy got=%b exp=0", BUSY); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_vector();
        test_zero_key_sweep();
        test_random_keys();
        test_hold_during_expand();
        test_back_to_back();
        test_reset_mid_expand();
        test_reset_with_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
